alu_op_sequencer: RTL and testbench

Control unit that runs the register-to-register ALU instruction class on the Phase 1 datapath. It fetches an instruction from PC through MAR/MDR into IR, decodes the opcode and register fields, and drives the datapath enables through the T0–T5 step sequence. It replaces hand-driven bench stimulus and sits between the memory handshake and the `Datapath` control inputs.

---
 rtl/riscie_ctrl_pkg.sv | 67 ++++++
 rtl/reg_select_decoder.sv | 25 ++
 rtl/alu_op_sequencer.sv | 210 +++++++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/riscie_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// riscie_ctrl_pkg
//
// Shared definitions for the register-to-register ALU instruction sequencer:
//   - state_t      : sequencer step encoding (IDLE, T0..T6, FAULT)
//   - OP_*         : opcode constants for the ALU instruction class
//   - *_MSB/*_LSB  : IR field bit positions (opcode, Ra, Rb, Rc)
//   - op_to_ctrl   : opcode -> ALU CONTROL select (opcode - 1, 5-bit wrap)
//   - op_is_legal  : legality check, with MUL/DIV gated by a build flag
//   - op_is_muldiv : true for the two-result opcodes (MUL, DIV)
// -----------------------------------------------------------------------------
package riscie_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_T0    = 4'd1,
    S_T1    = 4'd2,
    S_T2    = 4'd3,
    S_T3    = 4'd4,
    S_T4    = 4'd5,
    S_T5    = 4'd6,
    S_T6    = 4'd7,
    S_FAULT = 4'd8
  } state_t;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_SHR  = 5'b01001;
  localparam logic [4:0] OP_SHRA = 5'b01010;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;

  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 27;
  localparam int RA_MSB  = 26;
  localparam int RA_LSB  = 23;
  localparam int RB_MSB  = 22;
  localparam int RB_LSB  = 19;
  localparam int RC_MSB  = 18;
  localparam int RC_LSB  = 15;

  // ALU select is the opcode shifted down by one; ADD (3) maps to 2, etc.
  function automatic logic [4:0] op_to_ctrl(input logic [4:0] op);
    return op - 5'd1;
  endfunction

  function automatic logic op_is_muldiv(input logic [4:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

  function automatic logic op_is_legal(input logic [4:0] op, input logic muldiv_en);
    logic legal;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR,
      OP_ROL, OP_SHR, OP_SHRA, OP_SHL: legal = 1'b1;
      OP_MUL, OP_DIV:                  legal = muldiv_en;
      default:                         legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/reg_select_decoder.sv
// -----------------------------------------------------------------------------
// reg_select_decoder
//
// 4-to-16 one-hot decoder with enable, used to drive the GPR bus-drive and
// load-enable vectors from an IR register field.
//
// Ports:
//   en      in  1   decoder enable; all outputs 0 when low
//   sel     in  4   register index
//   onehot  out 16  one-hot select (bit sel set when en=1)
// -----------------------------------------------------------------------------
module reg_select_decoder (
  input  logic        en,
  input  logic [3:0]  sel,
  output logic [15:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en) begin
      onehot[sel] = 1'b1;
    end
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// -----------------------------------------------------------------------------
// alu_op_sequencer
//
// Control unit for the register-to-register ALU instruction class. Fetches
// PC -> MAR, waits for memory into MDR, loads IR, then steps the datapath
// through the operand reads, ALU operation and write-back.
//
// Build option: define ALU_SEQ_MULDIV_EN to make MUL/DIV legal. Those ops
// load ZHI in T4, write LO instead of a GPR in T5 and add a T6 step that
// moves ZHI into HI. Without it, T6 is never entered, the HI/LO/ZHI enables
// stay 0 and MUL/DIV opcodes fault.
//
// Ports:
//   Clock      in  1   rising-edge clock
//   Clear      in  1   asynchronous active-high reset (to IDLE, outputs 0)
//   Run        in  1   execute request; sampled in IDLE and the final step
//   Mem_Ready  in  1   memory data valid; sampled only in T1
//   IR_Q       in  32  current IR contents (opcode, Ra, Rb, Rc fields)
//   PC_Out, MDR_Out, ZLO_Out, ZHI_Out          out  bus drive enables
//   PC_In, MDR_In, MAR_In, IR_In, Y_In,
//   ZLO_In, ZHI_In, LO_In, HI_In               out  register load enables
//   IncPC, Read                                out  PC increment, mem read
//   CONTROL    out 5   ALU operation select
//   R_Out      out 16  one-hot GPR bus drive
//   R_In       out 16  one-hot GPR load
//   Done       out 1   final step of an instruction
//   Fault      out 1   illegal opcode seen; held until Clear
// -----------------------------------------------------------------------------
module alu_op_sequencer
  import riscie_ctrl_pkg::*;
(
  input  logic        Clock,
  input  logic        Clear,
  input  logic        Run,
  input  logic        Mem_Ready,
  input  logic [31:0] IR_Q,
  output logic        PC_Out,
  output logic        MDR_Out,
  output logic        ZLO_Out,
  output logic        ZHI_Out,
  output logic        PC_In,
  output logic        MDR_In,
  output logic        MAR_In,
  output logic        IR_In,
  output logic        Y_In,
  output logic        ZLO_In,
  output logic        ZHI_In,
  output logic        LO_In,
  output logic        HI_In,
  output logic        IncPC,
  output logic        Read,
  output logic [4:0]  CONTROL,
  output logic [15:0] R_Out,
  output logic [15:0] R_In,
  output logic        Done,
  output logic        Fault
);

`ifdef ALU_SEQ_MULDIV_EN
  localparam logic MULDIV_EN = 1'b1;
`else
  localparam logic MULDIV_EN = 1'b0;
`endif

  state_t state, state_nxt;

  logic [4:0] opc;
  logic [3:0] ra, rb, rc;
  logic       legal;
  logic       is_md;

  logic       rout_en, rin_en;
  logic [3:0] rout_sel;

  // Low IR bits carry no meaning for this instruction class.
  logic       unused_ir_low;
  assign unused_ir_low = ^IR_Q[RC_LSB-1:0];

  assign opc   = IR_Q[OPC_MSB:OPC_LSB];
  assign ra    = IR_Q[RA_MSB:RA_LSB];
  assign rb    = IR_Q[RB_MSB:RB_LSB];
  assign rc    = IR_Q[RC_MSB:RC_LSB];
  assign legal = op_is_legal(opc, MULDIV_EN);
  assign is_md = MULDIV_EN && op_is_muldiv(opc);

  // State register
  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  state_nxt = Run ? S_T0 : S_IDLE;
      S_T0:    state_nxt = S_T1;
      S_T1:    state_nxt = Mem_Ready ? S_T2 : S_T1;
      S_T2:    state_nxt = S_T3;
      S_T3:    state_nxt = legal ? S_T4 : S_FAULT;
      S_T4:    state_nxt = S_T5;
`ifdef ALU_SEQ_MULDIV_EN
      S_T5:    state_nxt = is_md ? S_T6 : (Run ? S_T0 : S_IDLE);
      S_T6:    state_nxt = Run ? S_T0 : S_IDLE;
`else
      S_T5:    state_nxt = Run ? S_T0 : S_IDLE;
`endif
      S_FAULT: state_nxt = S_FAULT;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Moore output decode from state and the latched IR fields
  always_comb begin
    PC_Out   = 1'b0;
    MDR_Out  = 1'b0;
    ZLO_Out  = 1'b0;
    ZHI_Out  = 1'b0;
    PC_In    = 1'b0;
    MDR_In   = 1'b0;
    MAR_In   = 1'b0;
    IR_In    = 1'b0;
    Y_In     = 1'b0;
    ZLO_In   = 1'b0;
    ZHI_In   = 1'b0;
    LO_In    = 1'b0;
    HI_In    = 1'b0;
    IncPC    = 1'b0;
    Read     = 1'b0;
    CONTROL  = 5'd0;
    Done     = 1'b0;
    Fault    = 1'b0;
    rout_en  = 1'b0;
    rout_sel = rb;
    rin_en   = 1'b0;
    case (state)
      S_T0: begin
        PC_Out = 1'b1;
        MAR_In = 1'b1;
        IncPC  = 1'b1;
        ZLO_In = 1'b1;
      end
      S_T1: begin
        // PC reload from ZLO repeats while waiting; the value is stable.
        ZLO_Out = 1'b1;
        PC_In   = 1'b1;
        Read    = 1'b1;
        MDR_In  = 1'b1;
      end
      S_T2: begin
        MDR_Out = 1'b1;
        IR_In   = 1'b1;
      end
      S_T3: begin
        if (legal) begin
          rout_en  = 1'b1;
          rout_sel = rb;
          Y_In     = 1'b1;
        end
      end
      S_T4: begin
        rout_en  = 1'b1;
        rout_sel = rc;
        ZLO_In   = 1'b1;
        CONTROL  = op_to_ctrl(opc);
`ifdef ALU_SEQ_MULDIV_EN
        ZHI_In   = is_md;
`endif
      end
      S_T5: begin
        ZLO_Out = 1'b1;
`ifdef ALU_SEQ_MULDIV_EN
        LO_In   = is_md;
        rin_en  = !is_md;
        Done    = !is_md;
`else
        rin_en  = 1'b1;
        Done    = 1'b1;
`endif
      end
`ifdef ALU_SEQ_MULDIV_EN
      S_T6: begin
        ZHI_Out = 1'b1;
        HI_In   = 1'b1;
        Done    = 1'b1;
      end
`endif
      S_FAULT: begin
        Fault = 1'b1;
      end
      default: ;
    endcase
  end

  reg_select_decoder u_rout_dec (
    .en     (rout_en),
    .sel    (rout_sel),
    .onehot (R_Out)
  );

  reg_select_decoder u_rin_dec (
    .en     (rin_en),
    .sel    (ra),
    .onehot (R_In)
  );

endmodule

// File: tb/tb_alu_op_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_op_sequencer
//
// Scoreboard bench: the driver plans each instruction from its opcode and
// register fields, pushes the control word expected for every cycle, and a
// monitor compares the DUT outputs each cycle against the queue head. The
// bench also stands in for the IR register, loading IR_Q while IR_In is up.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_alu_op_sequencer;

`ifdef ALU_SEQ_MULDIV_EN
  localparam bit MD_EN = 1'b1;
`else
  localparam bit MD_EN = 1'b0;
`endif

  typedef struct packed {
    logic        fault;
    logic        done;
    logic [4:0]  control;
    logic [15:0] r_out;
    logic [15:0] r_in;
    logic        pc_out, mdr_out, zlo_out, zhi_out;
    logic        pc_in, mdr_in, mar_in, ir_in, y_in;
    logic        zlo_in, zhi_in, lo_in, hi_in;
    logic        inc_pc, read;
  } ovec_t;

  logic        Clock = 1'b0;
  logic        Clear, Run, Mem_Ready;
  logic [31:0] IR_Q;
  logic        PC_Out, MDR_Out, ZLO_Out, ZHI_Out;
  logic        PC_In, MDR_In, MAR_In, IR_In, Y_In, ZLO_In, ZHI_In, LO_In, HI_In;
  logic        IncPC, Read, Done, Fault;
  logic [4:0]  CONTROL;
  logic [15:0] R_Out, R_In;

  int n_tests = 0;
  int n_fail  = 0;

  ovec_t exp_q[$];
  string tag_q[$];
  logic [31:0] cur_ir;

  always #5 Clock = ~Clock;

  alu_op_sequencer dut (
    .Clock(Clock), .Clear(Clear), .Run(Run), .Mem_Ready(Mem_Ready), .IR_Q(IR_Q),
    .PC_Out(PC_Out), .MDR_Out(MDR_Out), .ZLO_Out(ZLO_Out), .ZHI_Out(ZHI_Out),
    .PC_In(PC_In), .MDR_In(MDR_In), .MAR_In(MAR_In), .IR_In(IR_In), .Y_In(Y_In),
    .ZLO_In(ZLO_In), .ZHI_In(ZHI_In), .LO_In(LO_In), .HI_In(HI_In),
    .IncPC(IncPC), .Read(Read), .CONTROL(CONTROL), .R_Out(R_Out), .R_In(R_In),
    .Done(Done), .Fault(Fault)
  );

  function automatic ovec_t sample();
    ovec_t v;
    v.fault = Fault;     v.done = Done;       v.control = CONTROL;
    v.r_out = R_Out;     v.r_in = R_In;
    v.pc_out = PC_Out;   v.mdr_out = MDR_Out; v.zlo_out = ZLO_Out; v.zhi_out = ZHI_Out;
    v.pc_in = PC_In;     v.mdr_in = MDR_In;   v.mar_in = MAR_In;   v.ir_in = IR_In;
    v.y_in = Y_In;       v.zlo_in = ZLO_In;   v.zhi_in = ZHI_In;   v.lo_in = LO_In;
    v.hi_in = HI_In;     v.inc_pc = IncPC;    v.read = Read;
    return v;
  endfunction

  // ---- reference model: instruction rules expressed per step ----
  function automatic logic [31:0] mk(input int op, input int ra, input int rb, input int rc);
    logic [31:0] w;
    w = {op[4:0], ra[3:0], rb[3:0], rc[3:0], 15'($urandom)};
    return w;
  endfunction

  function automatic bit m_legal(input logic [31:0] ir);
    int op;
    op = int'(ir[31:27]);
    return (op >= 3 && op <= 11) || (MD_EN && (op == 15 || op == 16));
  endfunction

  function automatic bit m_md(input logic [31:0] ir);
    int op;
    op = int'(ir[31:27]);
    return MD_EN && (op == 15 || op == 16);
  endfunction

  function automatic ovec_t v_step(input string s, input logic [31:0] ir);
    ovec_t v;
    int ra, rb, rc, op;
    bit md;
    v  = '0;
    op = int'(ir[31:27]);
    ra = int'(ir[26:23]);
    rb = int'(ir[22:19]);
    rc = int'(ir[18:15]);
    md = m_md(ir);
    if (s == "T0") begin
      v.pc_out = 1; v.mar_in = 1; v.inc_pc = 1; v.zlo_in = 1;
    end else if (s == "T1") begin
      v.zlo_out = 1; v.pc_in = 1; v.read = 1; v.mdr_in = 1;
    end else if (s == "T2") begin
      v.mdr_out = 1; v.ir_in = 1;
    end else if (s == "T3") begin
      if (m_legal(ir)) begin
        v.r_out = 16'(1) << rb; v.y_in = 1;
      end
    end else if (s == "T4") begin
      v.r_out = 16'(1) << rc; v.zlo_in = 1; v.control = 5'(op + 31); v.zhi_in = md;
    end else if (s == "T5") begin
      v.zlo_out = 1;
      if (md) v.lo_in = 1;
      else    v.r_in = 16'(1) << ra;
      v.done = !md;
    end else if (s == "T6") begin
      v.zhi_out = 1; v.hi_in = 1; v.done = 1;
    end else if (s == "FAULT") begin
      v.fault = 1;
    end
    return v;
  endfunction

  // ---- monitor: one comparison per cycle against the queue head ----
  always @(posedge Clock) begin
    ovec_t e, a;
    string t;
    #2;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      a = sample();
      n_tests++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL sb_%s t=%0t got=%h want=%h", t, $time, a, e);
      end
    end
  end

  // ---- driver ----
  task automatic step(input logic run, input logic mr, input ovec_t e, input bit ld, input string tag);
    @(negedge Clock);
    Clear     = 1'b0;
    Run       = run;
    Mem_Ready = mr;
    if (ld) IR_Q = cur_ir;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic check_zero(input string name);
    ovec_t a;
    a = sample();
    n_tests++;
    if (a !== ovec_t'(0)) begin
      n_fail++;
      $display("FAIL %s got=%h want=0", name, a);
    end
  endtask

  task automatic clear_cycle();
    @(negedge Clock);
    Clear     = 1'b1;
    Run       = 1'($urandom);
    Mem_Ready = 1'($urandom);
    #1 check_zero("clear_async");
    exp_q.push_back('0); tag_q.push_back("clr_hold");
    step(1'b0, 1'($urandom), '0, 0, "post_clr0");
    step(1'b0, 1'($urandom), '0, 0, "post_clr1");
  endtask

  // Fetch + decode through T3; returns with the T3 expectation queued.
  task automatic fetch(input logic [31:0] ir, input int waits);
    cur_ir = ir;
    step(1'b1, 1'($urandom), v_step("T0", ir), 0, "T0");
    step(1'($urandom), 1'($urandom), v_step("T1", ir), 0, "T1");
    for (int i = 0; i < waits; i++)
      step(1'($urandom), 1'b0, v_step("T1", ir), 0, "T1w");
    step(1'($urandom), 1'b1, v_step("T2", ir), 0, "T2");
    step(1'($urandom), 1'($urandom), v_step("T3", ir), 1, "T3");
  endtask

  task automatic run_instr(input logic [31:0] ir, input int waits);
    fetch(ir, waits);
    if (!m_legal(ir)) begin
      for (int i = 0; i < 3; i++)
        step(1'($urandom), 1'($urandom), v_step("FAULT", ir), 0, "FAULT");
      clear_cycle();
    end else begin
      step(1'($urandom), 1'($urandom), v_step("T4", ir), 0, "T4");
      step(1'($urandom), 1'($urandom), v_step("T5", ir), 0, "T5");
      if (m_md(ir))
        step(1'($urandom), 1'($urandom), v_step("T6", ir), 0, "T6");
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step(1'b0, 1'($urandom), '0, 0, "IDLE");
  endtask

  int ops[16] = '{3, 4, 5, 6, 7, 8, 9, 10, 11, 15, 16, 0, 31, 12, 2, 17};

  initial begin
    Clear = 1'b1; Run = 1'b0; Mem_Ready = 1'b0; IR_Q = '0; cur_ir = '0;
    #1 check_zero("reset_state");
    repeat (2) @(posedge Clock);
    #1 check_zero("reset_held");
    idle(2);

    // ROL r5 <- r2, r4
    run_instr(mk(8, 5, 2, 4), 0);
    idle(1);
    // ADD with three wait cycles in T1
    run_instr(mk(3, 1, 6, 7), 3);
    idle(1);
    // Back-to-back ADDs with Run held
    run_instr(mk(3, 0, 0, 0), 0);
    run_instr(mk(3, 9, 9, 15), 1);
    idle(2);
    // Illegal opcode 11111
    run_instr(mk(31, 1, 2, 3), 0);
    idle(1);
    // Clear pulsed during T4 of a SUB
    fetch(mk(4, 3, 4, 5), 0);
    step(1'b1, 1'($urandom), v_step("T4", cur_ir), 0, "T4");
    clear_cycle();
    idle(2);
    // MUL / DIV (fault when the build leaves them out)
    run_instr(mk(15, 2, 3, 4), 0);
    run_instr(mk(16, 14, 13, 12), 2);
    idle(1);

    for (int k = 0; k < 40; k++) begin
      run_instr(mk(ops[$urandom_range(15)], $urandom_range(15), $urandom_range(15),
                   $urandom_range(15)), $urandom_range(3));
      if ($urandom_range(1) == 0) idle($urandom_range(2, 1));
    end
    idle(2);

    @(posedge Clock);
    #4;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain got=%0d want=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
